// File: rtl/key_inv_exp.sv
`default_nettype none
// ============================================================================
//  Module   : key_inv_exp
//  Purpose  : Byte-serial inverse AES-128 key-schedule step. Takes round key
//             N+1 one byte per cycle and returns round key N one byte per
//             cycle, using an external S-box with one cycle of read latency.
//             One instance per round; RCON is the forward round constant
//             being undone (8'h10 turns round key 5 into round key 4).
//  Ports    : clk          rising-edge clock
//             rst          synchronous active-high reset
//             din          round key N+1 byte, index order 0..15
//             enable_din   din valid (only taken while din_ready is high)
//             din_ready    high while the block is loading a key
//             addr_out     S-box address
//             enable_sbox  addr_out valid
//             sbox_in      S-box data for the previous cycle's address
//             out_req      downstream ready for round key N (level)
//             dout         round key N byte, index order 0..15
//             enable_out   dout valid
//  Byte map : byte i = 4*row + col; column c holds bytes c, c+4, c+8, c+12.
//  Revision : 1.0  initial release
// ============================================================================
module key_inv_exp #(
    parameter logic [7:0] RCON = 8'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       enable_din,
    output logic       din_ready,
    output logic [7:0] addr_out,
    output logic       enable_sbox,
    input  logic [7:0] sbox_in,
    input  logic       out_req,
    output logic [7:0] dout,
    output logic       enable_out
);

    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_XORC = 3'd1,
        ST_SUB  = 3'd2,
        ST_COL0 = 3'd3,
        ST_WAIT = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    // Last value of the per-state step counter.
    localparam logic [3:0] C_LOAD_LAST = 4'd15;
    localparam logic [3:0] C_XORC_LAST = 4'd2;
    localparam logic [3:0] C_SUB_LAST  = 4'd4;
    localparam logic [3:0] C_OUT_LAST  = 4'd15;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    // Key storage is rewritten in place: columns 3..1 become p3..p1 during
    // XORC and column 0 becomes p0 in COL0, so no second key buffer exists.
    logic [7:0] r_key [16];
    logic [7:0] r_sub [4];

    logic       r_din_ready;
    logic [7:0] r_addr;
    logic       r_en_sbox;
    logic [7:0] r_dout;
    logic       r_en_out;

    logic       w_din_ready_nxt;
    logic [7:0] w_addr_nxt;
    logic       w_en_sbox_nxt;
    logic [7:0] w_dout_nxt;
    logic       w_en_out_nxt;

    // RotWord order: SUB step k looks up row k+1 (mod 4) of column 3.
    logic [1:0] w_rot_row;
    // XORC step k rewrites column 3-k from itself and its left neighbour.
    logic [1:0] w_xor_col;
    logic [1:0] w_xor_src;
    // S-box data arrives one cycle after the address, so SUB step k (k>=1)
    // captures sub[k-1]; step 4 wraps to index 3.
    logic [1:0] w_sub_idx;

    assign w_rot_row = w_cnt_nxt[1:0] + 2'd1;
    assign w_xor_col = 2'd3 - r_cnt[1:0];
    assign w_xor_src = w_xor_col - 2'd1;
    assign w_sub_idx = r_cnt[1:0] - 2'd1;

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_LOAD;
            r_cnt       <= 4'd0;
            r_din_ready <= 1'b1;
            r_addr      <= 8'h00;
            r_en_sbox   <= 1'b0;
            r_dout      <= 8'h00;
            r_en_out    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_din_ready <= w_din_ready_nxt;
            r_addr      <= w_addr_nxt;
            r_en_sbox   <= w_en_sbox_nxt;
            r_dout      <= w_dout_nxt;
            r_en_out    <= w_en_out_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and next registered outputs. Outputs are derived from
    // the upcoming state so each one is visible during the cycle the
    // block actually spends in that state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_din_ready_nxt = 1'b0;
        w_addr_nxt      = 8'h00;
        w_en_sbox_nxt   = 1'b0;
        w_dout_nxt      = 8'h00;
        w_en_out_nxt    = 1'b0;

        case (r_state)
            ST_LOAD: begin
                if (enable_din) begin
                    if (r_cnt == C_LOAD_LAST) begin
                        w_state_nxt = ST_XORC;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            ST_XORC: begin
                if (r_cnt == C_XORC_LAST) begin
                    w_state_nxt = ST_SUB;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_SUB: begin
                if (r_cnt == C_SUB_LAST) begin
                    w_state_nxt = ST_COL0;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_COL0: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = 4'd0;
            end
            ST_WAIT: begin
                if (out_req) begin
                    w_state_nxt = ST_OUT;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ST_OUT: begin
                // The burst is committed once started; out_req is not
                // looked at again until the next key.
                if (r_cnt == C_OUT_LAST) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        w_din_ready_nxt = (w_state_nxt == ST_LOAD);

        // SUB steps 0..3 issue lookups; step 4 only collects the last reply.
        if ((w_state_nxt == ST_SUB) && (w_cnt_nxt[3:2] == 2'b00)) begin
            w_en_sbox_nxt = 1'b1;
            w_addr_nxt    = r_key[{w_rot_row, 2'd3}];
        end

        if (w_state_nxt == ST_OUT) begin
            w_en_out_nxt = 1'b1;
            w_dout_nxt   = r_key[w_cnt_nxt];
        end
    end

    // ------------------------------------------------------------------
    // Key datapath (not reset; contents are only meaningful after a load)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        case (r_state)
            ST_LOAD: begin
                if (enable_din) begin
                    r_key[r_cnt] <= din;
                end
            end
            ST_XORC: begin
                for (int r = 0; r < 4; r++) begin
                    r_key[{2'(r), w_xor_col}] <= r_key[{2'(r), w_xor_col}]
                                               ^ r_key[{2'(r), w_xor_src}];
                end
            end
            ST_SUB: begin
                if (r_cnt != 4'd0) begin
                    r_sub[w_sub_idx] <= sbox_in;
                end
            end
            ST_COL0: begin
                for (int r = 0; r < 4; r++) begin
                    r_key[{2'(r), 2'd0}] <= r_key[{2'(r), 2'd0}] ^ r_sub[r]
                                          ^ ((r == 0) ? RCON : 8'h00);
                end
            end
            default: begin
            end
        endcase
    end

    assign din_ready   = r_din_ready;
    assign addr_out    = r_addr;
    assign enable_sbox = r_en_sbox;
    assign dout        = r_dout;
    assign enable_out  = r_en_out;

endmodule
`default_nettype wire

// File: tb/tb_key_inv_exp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_inv_exp
//  Purpose  : Self-checking bench for key_inv_exp. Provides a registered
//             AES S-box responder, drives keys with gaps and stray
//             enable_din pulses, and compares every output burst against
//             fixed FIPS-197 vectors or a word-level inverse key-step model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_inv_exp;

    localparam logic [7:0]   RCON_TB = 8'h10;
    localparam logic [127:0] KEY_A   = 128'hd47cca11_d183f2f9_c69db815_f887bcbc;
    localparam logic [127:0] EXP_A   = 128'hefa8b6db_4452710b_a55b25ad_417f3b00;
    localparam logic [31:0]  ADDR_A  = 32'h0bad00db;
    localparam logic [127:0] KEY_Z   = 128'h0;
    localparam logic [127:0] EXP_Z   = 128'h73000000_63000000_63000000_63000000;
    localparam logic [31:0]  ADDR_Z  = 32'h00000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       enable_din;
    logic       din_ready;
    logic [7:0] addr_out;
    logic       enable_sbox;
    logic [7:0] sbox_in = 8'h00;
    logic       out_req;
    logic [7:0] dout;
    logic       enable_out;

    int checks = 0;
    int errors = 0;
    int pcyc   = 0;

    logic [7:0] sbox_t [256];
    logic [7:0] out_q [$];
    int         ocyc_q [$];
    logic [7:0] addr_q [$];
    int         acyc_q [$];

    key_inv_exp #(.RCON(RCON_TB)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .enable_din  (enable_din),
        .din_ready   (din_ready),
        .addr_out    (addr_out),
        .enable_sbox (enable_sbox),
        .sbox_in     (sbox_in),
        .out_req     (out_req),
        .dout        (dout),
        .enable_out  (enable_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    // External S-box: data for this cycle's address appears next cycle.
    always @(posedge clk) sbox_in <= enable_sbox ? sbox_t[addr_out] : 8'h00;

    always @(negedge clk) begin
        if (enable_out) begin
            out_q.push_back(dout);
            ocyc_q.push_back(pcyc);
        end
        if (enable_sbox) begin
            addr_q.push_back(addr_out);
            acyc_q.push_back(pcyc);
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            repeat (254) inv = gmul(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_f(8'(i));
    end

    // Word-level inverse key step. Keys are packed with byte 0 at the MSB.
    function automatic logic [127:0] model_prev(input logic [127:0] k, output logic [31:0] rot);
        logic [31:0]  n [4];
        logic [31:0]  p [4];
        logic [31:0]  s;
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                n[c][31-8*r -: 8] = k[127-8*(4*r+c) -: 8];
        p[3] = n[3] ^ n[2];
        p[2] = n[2] ^ n[1];
        p[1] = n[1] ^ n[0];
        rot  = {p[3][23:0], p[3][31:24]};
        for (int r = 0; r < 4; r++) s[31-8*r -: 8] = sbox_t[rot[31-8*r -: 8]];
        p[0] = n[0] ^ s ^ {RCON_TB, 24'h000000};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*r+c) -: 8] = p[c][31-8*r -: 8];
        return res;
    endfunction

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_din_ready"}, din_ready, 1);
        check_value({tag, "_enable_out"}, enable_out, 0);
        check_value({tag, "_enable_sbox"}, enable_sbox, 0);
        check_value({tag, "_dout"}, dout, 0);
        check_value({tag, "_addr_out"}, addr_out, 0);
    endtask

    // mode 0: enable_din every cycle, 1: toggled 1/0, 2: random gaps.
    // junk: random enable_din pulses whenever the DUT is not loading.
    task automatic load_key(input logic [127:0] key, input int mode, input bit junk,
                            input int nbytes, output int t_last);
        int idx   = 0;
        int guard = 0;
        bit en;
        t_last = -1;
        out_q.delete(); ocyc_q.delete(); addr_q.delete(); acyc_q.delete();
        while (idx < nbytes && guard < 300) begin
            case (mode)
                0:       en = 1'b1;
                1:       en = (guard % 2 == 0);
                default: en = 1'($urandom_range(0, 1));
            endcase
            if (din_ready) begin
                enable_din = en;
                din        = en ? key[127-8*idx -: 8] : 8'($urandom);
                if (en) begin
                    if (idx == nbytes - 1) t_last = pcyc;
                    idx++;
                end
            end else begin
                enable_din = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                din        = 8'($urandom);
            end
            tick();
            guard++;
        end
        enable_din = 1'b0;
        check_value("load_count", idx, nbytes);
    endtask

    task automatic wait_burst(input logic [127:0] exp_out, input logic [31:0] exp_addr,
                              input int t_last, input int delay, input bit junk);
        int guard = 0;
        int rcyc  = -1;
        logic [127:0] pk = '0;
        logic [31:0]  pa = '0;
        while (rcyc < 0 && guard < 400) begin
            if (delay > 0 && pcyc >= t_last + 10 + delay) out_req = 1'b1;
            if (din_ready) begin
                rcyc       = pcyc;
                enable_din = 1'b0;
            end else begin
                enable_din = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                din        = 8'($urandom);
                tick();
                guard++;
            end
        end
        for (int i = 0; i < out_q.size(); i++) pk = {pk[119:0], out_q[i]};
        for (int i = 0; i < addr_q.size(); i++) pa = {pa[23:0], addr_q[i]};
        check_value("out_count", out_q.size(), 16);
        check_value("dout", pk, exp_out);
        check_value("addr_count", addr_q.size(), 4);
        check_value("addr_out", pa, exp_addr);
        check_value("ready_cycle", rcyc - t_last, 27 + delay);
        if (acyc_q.size() > 0) check_value("addr_first_cycle", acyc_q[0] - t_last, 4);
        if (ocyc_q.size() > 0) begin
            check_value("out_first_cycle", ocyc_q[0] - t_last, 11 + delay);
            check_value("out_last_cycle", ocyc_q[ocyc_q.size()-1] - t_last, 26 + delay);
        end
    endtask

    task automatic run_key(input logic [127:0] key, input logic [127:0] exp_out,
                           input logic [31:0] exp_addr, input int mode, input bit junk,
                           input int delay);
        int t;
        out_req = (delay == 0);
        load_key(key, mode, junk, 16, t);
        wait_burst(exp_out, exp_addr, t, delay, junk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int t;
        int guard;
        logic [127:0] rk;
        logic [127:0] re;
        logic [31:0]  ra;

        rst = 1'b1; din = 8'h00; enable_din = 1'b0; out_req = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // FIPS-197 vector, out_req tied high.
        run_key(KEY_A, EXP_A, ADDR_A, 0, 1'b0, 0);
        // All-zero key.
        run_key(KEY_Z, EXP_Z, ADDR_Z, 0, 1'b0, 0);
        // Toggled enable_din, out_req held low 20 cycles in WAIT.
        run_key(KEY_A, EXP_A, ADDR_A, 1, 1'b0, 20);

        // Reset after 7 bytes, then a clean full load.
        out_req = 1'b1;
        load_key(KEY_A, 0, 1'b0, 7, t);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_load_rst");
        rst = 1'b0;
        run_key(KEY_A, EXP_A, ADDR_A, 0, 1'b0, 0);

        // Reset in the middle of an output burst.
        out_req = 1'b1;
        load_key(KEY_A, 0, 1'b0, 16, t);
        guard = 0;
        while (out_q.size() < 5 && guard < 100) begin
            tick();
            guard++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("mid_out_rst_enable_out", enable_out, 0);
        check_value("mid_out_rst_din_ready", din_ready, 1);
        check_value("mid_out_rst_dout", dout, 0);
        repeat (8) tick();
        check_value("mid_out_rst_count", out_q.size(), 5);

        // Back-to-back keys with stray enable_din pulses.
        run_key(KEY_A, EXP_A, ADDR_A, 0, 1'b1, 0);
        run_key(KEY_Z, EXP_Z, ADDR_Z, 0, 1'b1, 0);

        // Random keys against the reference model.
        for (int n = 0; n < 8; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            re = model_prev(rk, ra);
            run_key(rk, re, ra, 2, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_inv_exp.md
Name: key_inv_exp

Overview:
- Byte-serial inverse AES-128 key-schedule step for the decryption path.
- Accepts round key N+1 and produces round key N, so decryption rounds can walk the schedule backwards without storing every round key.
- Uses the same external S-box lookup interface as the forward key-expansion blocks: address out with an enable, data back one cycle later.
- One instance per round, selected by parameter RCON.

Parameters:
- RCON, 8'h10, round constant of the forward step being undone (8'h10 undoes round 5, giving round key 4).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- din  in  8  round key N+1 byte.
- enable_din  in  1  din valid this cycle.
- din_ready  out  1  high while in LOAD; bytes are accepted only then.
- addr_out  out  8  S-box address.
- enable_sbox  out  1  addr_out valid.
- sbox_in  in  8  S-box data; corresponds to the addr_out/enable_sbox of the previous cycle.
- out_req  in  1  downstream ready to take round key N (level).
- dout  out  8  round key N byte.
- enable_out  out  1  dout valid.

Behaviour:
- Byte layout for both input and output:
  - Byte index i = 4*row + col.
  - Word/column c is bytes c, c+4, c+8, c+12 (row 0 first).
  - Input and output are both in index order 0..15.
- Math, with n = next key words and p = previous key words:
  - p3 = n3^n2
  - p2 = n2^n1
  - p1 = n1^n0
  - p0 = n0 ^ SubWord(RotWord(p3)) ^ {RCON,00,00,00}
  - All arithmetic is 8-bit XOR. There is no carry and no width growth.
- Reset values:
  - State = LOAD.
  - Counters = 0.
  - enable_out = 0, enable_sbox = 0, dout = 0, addr_out = 0, din_ready = 1.
  - Key storage is not reset.
- LOAD:
  - Each cycle with enable_din=1 stores din at the byte counter and increments it.
  - Gaps in enable_din are allowed.
  - After byte 15 is stored, go to XORC. din_ready drops in that same cycle's registered update.
- XORC: 3 cycles.
  - Computes p3, p2, p1, one full column (4 bytes) per cycle, in that order.
- SUB: 5 cycles.
  - Cycles 0-3: enable_sbox=1, addr_out = p3 rows 1,2,3,0 in turn (RotWord order).
  - Cycles 1-4: sbox_in is captured as sub[0..3].
  - Cycle 4: enable_sbox=0.
- COL0: 1 cycle.
  - p0 row r = n0 row r ^ sub[r], and additionally ^ RCON when r = 0.
- WAIT:
  - Hold until out_req=1.
  - Nothing is presented before out_req.
  - enable_din is ignored here and in every other non-LOAD state.
- OUT: 16 consecutive cycles.
  - enable_out=1, dout = p[0]..p[15].
  - out_req is not rechecked during the burst.
  - The cycle after p[15]: enable_out=0, state returns to LOAD with counter 0 and din_ready=1.
- Latency:
  - Last input byte accepted at cycle T.
  - S-box addresses issued at T+4..T+7.
  - WAIT entered at T+10.
  - If out_req is already high, first dout/enable_out at T+11 and last at T+26.
- Boundaries:
  - rst at any cycle, including mid-LOAD or mid-OUT, returns to the reset values on the next edge. Partial keys are discarded and enable_out/enable_sbox drop immediately.
  - enable_din together with the 16th-byte transition: only 16 bytes are consumed; extra bytes are dropped.
  - Back-to-back keys: a new key may start being accepted the cycle after the OUT burst ends.

Test Plan:
- FIPS-197 A.1, round 5 to round 4, RCON=10:
  - Stimulus: din = d4 7c ca 11 d1 83 f2 f9 c6 9d b8 15 f8 87 bc bc.
  - Required: addr_out sequence 0b ad 00 db.
  - Required (bench S-box returns 2b 95 63 b9): dout = ef a8 b6 db 44 52 71 0b a5 5b 25 ad 41 7f 3b 00.
  - Required: first byte at T+11 with out_req tied high.
- All-zero input, RCON=10:
  - Required: four addr_out=00.
  - Required: dout = 73 00 00 00 63 00 00 00 63 00 00 00 63 00 00 00.
- Same vector as the first scenario with enable_din toggled 1/0 every cycle and out_req held low 20 cycles after WAIT:
  - Required: identical output.
  - Required: enable_out stays 0 until the cycle after out_req rises.
  - Required: burst is exactly 16 cycles.
- rst pulsed after 7 bytes loaded, then the full first-scenario vector:
  - Required: output matches the first scenario; no stale bytes.
- rst pulsed mid-OUT (after 5 bytes):
  - Required: enable_out=0 the next cycle, din_ready=1, no further dout.
- Two keys back-to-back (first scenario, then all-zero) with extra enable_din pulses during XORC/SUB/OUT:
  - Required: both expected outputs in order; extra bytes ignored.
